// File: rtl/sh_wdt_gen.sv
// sh_wdt_gen: SH-family watchdog / interval timer with internal 13-bit prescaler,
// keyed IBUS register window and WDTOVF_N / reset-request pulse generator.
module sh_wdt_gen #(
  parameter int          CNT_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFE80,
  parameter int          OVF_LEN   = 128,
  parameter int          RES_LEN   = 512,
  parameter bit          DISABLE   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic        RES_N,
  input  logic        SBY,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic [31:0] IBUS_DO,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        WDTOVF_N,
  output logic        ITI_IRQ,
  output logic        PRES,
  output logic        MRES
);
  typedef enum logic {IDLE, PULSE} state_t;
  localparam logic [9:0] OVF_C = 10'(OVF_LEN);
  localparam logic [9:0] RES_C = 10'(RES_LEN);
  state_t state_q;
  logic [9:0] pcnt_q;
  logic wdtovf_n_q, wres_q;
  logic ovf_q, ovf_d, wtit_q, wtit_d, tme_q, tme_d;
  logic wovf_q, wovf_d, rste_q, rste_d, rsts_q, rsts_d;
  logic [2:0] cks_q, cks_d;
  logic [CNT_W-1:0] wtcnt_q, wtcnt_d;
  logic [12:0] presc_q, presc_d, mask;
  logic [3:0] lg;
  logic [31:0] off, reg_do_q, rd_val;
  logic [1:0] idx;
  logic active, reg_sel, wr, rd, tick, cnt_en, wrap, wdt_evt;
  logic wr_csr, wr_cnt, wr_rs, wr_wc, unused;
  assign unused = ^{IBUS_BA, IBUS_DI};
  assign active = CE_R & EN & ~DISABLE;
  assign off = IBUS_A - BASE_ADDR;
  assign reg_sel = off < 32'd12;
  assign idx = off[3:2];
  assign wr = active & reg_sel & IBUS_WE & IBUS_REQ;
  assign rd = CE_F & ~DISABLE & reg_sel & ~IBUS_WE & IBUS_REQ;
  assign wr_csr = wr & (idx == 2'd0) & (IBUS_DI[15:8] == 8'hA5);
  assign wr_cnt = wr & (idx == 2'd1) & (IBUS_DI[31:24] == 8'h5A);
  assign wr_rs = wr & (idx == 2'd2) & (IBUS_DI[15:8] == 8'h5A);
  assign wr_wc = wr & (idx == 2'd2) & (IBUS_DI[15:8] == 8'hA5) & ~IBUS_DI[7];
  // divide ratios 2,64..1024,4096,8192 -> prescaler low-bit count 1,6..10,12,13
  assign lg = cks_q == 3'd0 ? 4'd1 : cks_q >= 3'd6 ? {1'b0, cks_q} + 4'd6 : {1'b0, cks_q} + 4'd5;
  assign mask = 13'((14'd1 << lg) - 14'd1);
  assign tick = active & ((presc_q & mask) == mask);
  assign cnt_en = tick & tme_q & ~ovf_q;
  assign wrap = cnt_en & (&wtcnt_q);
  assign wdt_evt = wrap & wtit_q;
  assign rd_val = idx == 2'd0 ? {24'd0, ovf_q, wtit_q, tme_q, 2'b11, cks_q} :
                  idx == 2'd1 ? 32'(wtcnt_q) : {24'd0, wovf_q, rste_q, rsts_q, 5'h1F};
  always_comb begin
    {ovf_d, wtit_d, tme_d, cks_d} = {ovf_q, wtit_q, tme_q, cks_q};
    {wovf_d, rste_d, rsts_d} = {wovf_q, rste_q, rsts_q};
    wtcnt_d = wtcnt_q;
    presc_d = presc_q;
    if (active) begin
      presc_d = tme_q ? presc_q + 13'd1 : 13'd0;
      wtcnt_d = cnt_en ? wtcnt_q + CNT_W'(1) : wtcnt_q;
      if (wr_csr) begin
        {wtit_d, tme_d, cks_d} = {IBUS_DI[6:5], IBUS_DI[2:0]};
        ovf_d = ovf_q & IBUS_DI[7] & IBUS_DI[5];
        wtcnt_d = IBUS_DI[5] ? wtcnt_d : '0;
      end
      if (wr_cnt) wtcnt_d = IBUS_DI[CNT_W-1:0];
      if (wr_rs) {rste_d, rsts_d} = IBUS_DI[6:5];
      if (wr_wc) wovf_d = 1'b0;
      // hardware flag sets are applied last so they win over a same-cycle clear
      if (wrap & ~wtit_q) ovf_d = 1'b1;
      if (wdt_evt) begin
        wovf_d = 1'b1;
        {ovf_d, wtit_d, tme_d, cks_d} = '0;
      end
      if (SBY) begin
        wtcnt_d = '0;
        presc_d = '0;
        {ovf_d, wtit_d, tme_d, rste_d, rsts_d} = '0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N || !RES_N) begin
      {ovf_q, wtit_q, tme_q, cks_q} <= '0;
      {rste_q, rsts_q} <= '0;
      wovf_q <= RST_N & wovf_q;
      wtcnt_q <= '0;
      presc_q <= '0;
      reg_do_q <= '0;
    end else begin
      {ovf_q, wtit_q, tme_q, cks_q} <= {ovf_d, wtit_d, tme_d, cks_d};
      {wovf_q, rste_q, rsts_q} <= {wovf_d, rste_d, rsts_d};
      wtcnt_q <= wtcnt_d;
      presc_q <= presc_d;
      if (rd) reg_do_q <= rd_val;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N || !RES_N) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      wdtovf_n_q <= 1'b1;
      wres_q <= 1'b0;
    end else if (active) begin
      if (state_q == IDLE) begin
        if (wdt_evt) begin
          state_q <= PULSE;
          pcnt_q <= '0;
          wdtovf_n_q <= 1'b0;
          wres_q <= rste_q;
        end
      end else begin
        pcnt_q <= pcnt_q + 10'd1;
        if (pcnt_q + 10'd1 == OVF_C) wdtovf_n_q <= 1'b1;
        if (pcnt_q + 10'd1 == RES_C) begin
          wres_q <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign IBUS_DO = (reg_sel & ~DISABLE) ? reg_do_q : 32'd0;
  assign IBUS_ACT = reg_sel & ~DISABLE;
  assign IBUS_BUSY = 1'b0;
  assign WDTOVF_N = wdtovf_n_q;
  assign ITI_IRQ = ovf_q;
  assign PRES = wres_q & ~rsts_q;
  assign MRES = wres_q & rsts_q;
endmodule
